// File: rtl/prio_index_encoder_tx_if.sv
// Stream bundle for prio_index_encoder_tx.
//   in_*      : index stream from the producer (valid/ready)
//   out_*     : select-word stream to the consumer (valid/ready)
//   word_cnt  : words consumed downstream, err : sticky error flag
// master = the side that feeds indices and consumes words (bench/host),
// slave  = the encoder block itself.
interface prio_index_encoder_tx_if #(
    parameter int WIDTH = 32,
    parameter int IDXW  = 5,
    parameter int CNTW  = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [IDXW-1:0]   in_idx;
    logic [1:0]        in_mode;
    logic [WIDTH-1:0]  in_fill;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_sel;
    logic [IDXW-1:0]   out_idx;
    logic [CNTW-1:0]   word_cnt;
    logic              err;

    modport master (
        output in_valid, in_idx, in_mode, in_fill, out_ready,
        input  in_ready, out_valid, out_sel, out_idx, word_cnt, err
    );

    modport slave (
        input  in_valid, in_idx, in_mode, in_fill, out_ready,
        output in_ready, out_valid, out_sel, out_idx, word_cnt, err
    );
endinterface

// File: rtl/prio_index_encoder_tx.sv
// prio_index_encoder_tx
// Inverse of the leading-one priority encoder: turns an index stream into the
// select word that the encoder maps back to the same index. Index i puts its
// leading one at bit WIDTH-1-i (MSB = priority 0).
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous reset, active low
//   bus    : slave side of prio_index_encoder_tx_if (in/out streams,
//            word_cnt, err)
// Modes: 0 one-hot, 1 thermometer (p..0), 2 leading one + in_fill below,
// 3 reserved (one-hot, flags err). IDXW must satisfy 2**IDXW >= WIDTH.
// Datapath: one output register plus a one-entry skid buffer, so in_ready is
// a flop and never depends combinationally on out_ready.
module prio_index_encoder_tx #(
    parameter int WIDTH = 32,
    parameter int IDXW  = 5,
    parameter int CNTW  = 16
) (
    input logic                    clk,
    input logic                    rst_n,
    prio_index_encoder_tx_if.slave bus
);

    logic              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  out_sel_q,   out_sel_d;
    logic [IDXW-1:0]   out_idx_q,   out_idx_d;
    logic              skid_full_q, skid_full_d;
    logic [WIDTH-1:0]  skid_sel_q,  skid_sel_d;
    logic [IDXW-1:0]   skid_idx_q,  skid_idx_d;
    logic [CNTW-1:0]   cnt_q,       cnt_d;
    logic              err_q,       err_d;

    logic              acc;
    logic              fire;
    logic [WIDTH-1:0]  enc_sel;
    logic              enc_bad;
    int                pos;

    assign acc  = bus.in_valid && !skid_full_q;
    assign fire = out_valid_q && bus.out_ready;

    // Select-word generation for the word being offered this cycle.
    always_comb begin
        enc_sel = '0;
        enc_bad = 1'b0;
        pos     = WIDTH - 1 - int'(bus.in_idx);
        if (int'(bus.in_idx) >= WIDTH) begin
            // Unreachable index for this width: emit an all-zero word.
            enc_bad = 1'b1;
        end else begin
            if (bus.in_mode == 2'd3) enc_bad = 1'b1;
            for (int b = 0; b < WIDTH; b++) begin
                case (bus.in_mode)
                    2'd1:    enc_sel[b] = (b <= pos);
                    2'd2:    enc_sel[b] = (b == pos) || ((b < pos) && bus.in_fill[b]);
                    default: enc_sel[b] = (b == pos);
                endcase
            end
        end
    end

    // Output/skid steering.
    always_comb begin
        out_valid_d = out_valid_q;
        out_sel_d   = out_sel_q;
        out_idx_d   = out_idx_q;
        skid_full_d = skid_full_q;
        skid_sel_d  = skid_sel_q;
        skid_idx_d  = skid_idx_q;
        cnt_d       = cnt_q;
        err_d       = err_q | (acc & enc_bad);
        if (fire) cnt_d = cnt_q + CNTW'(1);

        if (!out_valid_q || fire) begin
            // Output stage frees up. A full skid has priority; acc is
            // necessarily 0 then because in_ready was low.
            if (skid_full_q) begin
                out_valid_d = 1'b1;
                out_sel_d   = skid_sel_q;
                out_idx_d   = skid_idx_q;
                skid_full_d = 1'b0;
            end else if (acc) begin
                out_valid_d = 1'b1;
                out_sel_d   = enc_sel;
                out_idx_d   = bus.in_idx;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (acc) begin
            // Output stalled: park the new word in the skid entry.
            skid_full_d = 1'b1;
            skid_sel_d  = enc_sel;
            skid_idx_d  = bus.in_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_sel_q   <= '0;
            out_idx_q   <= '0;
            skid_full_q <= 1'b0;
            skid_sel_q  <= '0;
            skid_idx_q  <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_sel_q   <= out_sel_d;
            out_idx_q   <= out_idx_d;
            skid_full_q <= skid_full_d;
            skid_sel_q  <= skid_sel_d;
            skid_idx_q  <= skid_idx_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
        end
    end

    assign bus.in_ready  = !skid_full_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sel   = out_sel_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.word_cnt  = cnt_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_prio_index_encoder_tx.sv
module tb_prio_index_encoder_tx;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    prio_index_encoder_tx_if #(.WIDTH(32), .IDXW(5), .CNTW(16)) bus ();

    prio_index_encoder_tx #(.WIDTH(32), .IDXW(5), .CNTW(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [4:0]  idx;
        logic [31:0] sel;
        bit          rt;
    } exp_t;

    exp_t        q[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] exp_cnt = '0;
    bit          prev_stall = 0;
    logic [31:0] prev_sel;
    logic [4:0]  prev_idx;
    logic [31:0] cur_exp;
    bit          cur_rt;
    bit          rnd_rdy = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    // Reference leading-one encoder: index of the highest set bit, MSB = 0.
    function automatic logic [31:0] penc(input logic [31:0] s);
        for (int b = 31; b >= 0; b--)
            if (s[b]) return 32'(31 - b);
        return 32'd32;
    endfunction

    function automatic logic [31:0] model(input logic [4:0] idx, input logic [1:0] mode,
                                          input logic [31:0] fill);
        logic [31:0] oh;
        logic [31:0] all1;
        oh   = 32'h8000_0000 >> idx;
        all1 = 32'hFFFF_FFFF;
        case (mode)
            2'd1:    return all1 >> idx;
            2'd2:    return oh | (fill & (oh - 32'd1));
            default: return oh;
        endcase
    endfunction

    // One clock: observe at negedge, then return just after the next posedge.
    task automatic step(output bit acc);
        exp_t e;
        @(negedge clk);
        acc = bus.in_valid && bus.in_ready;
        chk("cnt", 32'(bus.word_cnt), 32'(exp_cnt));
        if (prev_stall) begin
            chk("hold_v",   32'(bus.out_valid), 32'd1);
            chk("hold_sel", bus.out_sel, prev_sel);
            chk("hold_idx", 32'(bus.out_idx), 32'(prev_idx));
        end
        if (bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) begin
                chk("spurious", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                chk("sel", bus.out_sel, e.sel);
                chk("idx", 32'(bus.out_idx), 32'(e.idx));
                if (e.rt) chk("roundtrip", penc(bus.out_sel), 32'(bus.out_idx));
            end
            exp_cnt++;
        end
        if (acc) q.push_back('{idx: bus.in_idx, sel: cur_exp, rt: cur_rt});
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_sel   = bus.out_sel;
        prev_idx   = bus.out_idx;
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [4:0] idx, input logic [1:0] mode,
                         input logic [31:0] fill, input logic [31:0] exp_sel);
        bus.in_valid = 1'b1;
        bus.in_idx   = idx;
        bus.in_mode  = mode;
        bus.in_fill  = fill;
        cur_exp      = exp_sel;
        cur_rt       = (mode != 2'd3);
    endtask

    task automatic wait_acc();
        bit a;
        int n;
        n = 0;
        do begin
            if (rnd_rdy) bus.out_ready = 1'($urandom_range(0, 1));
            step(a);
            n++;
        end while (!a && n < 200);
        if (!a) chk("acc_timeout", 32'd0, 32'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic send(input logic [4:0] idx, input logic [1:0] mode,
                        input logic [31:0] fill, input logic [31:0] exp_sel);
        offer(idx, mode, fill, exp_sel);
        wait_acc();
    endtask

    task automatic drain();
        bit a;
        int n;
        n = 0;
        bus.out_ready = 1'b1;
        while ((q.size() != 0 || bus.out_valid) && n < 200) begin
            step(a);
            n++;
        end
        if (n >= 200) chk("drain_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        bit a;
        logic [31:0] f;
        bus.in_valid  = 1'b0;
        bus.in_idx    = '0;
        bus.in_mode   = '0;
        bus.in_fill   = '0;
        bus.out_ready = 1'b1;
        cur_exp       = '0;
        cur_rt        = 0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_sel",   bus.out_sel, 32'd0);
        chk("rst_idx",   32'(bus.out_idx), 32'd0);
        chk("rst_cnt",   32'(bus.word_cnt), 32'd0);
        chk("rst_err",   32'(bus.err), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_ready", 32'(bus.in_ready), 32'd1);

        // 1: idx 0 one-hot, 1-cycle latency, count after handshake
        send(5'd0, 2'd0, 32'h0, 32'h8000_0000);
        chk("t1_valid", 32'(bus.out_valid), 32'd1);
        chk("t1_sel",   bus.out_sel, 32'h8000_0000);
        step(a);
        chk("t1_cnt",   32'(bus.word_cnt), 32'd1);

        // 2: thermometer
        send(5'd31, 2'd1, 32'h0, 32'h0000_0001);
        send(5'd4,  2'd1, 32'h0, 32'h0FFF_FFFF);
        drain();

        // 3: fill mode
        send(5'd5, 2'd2, 32'hFFFF_FFFF, 32'h07FF_FFFF);
        send(5'd5, 2'd2, 32'h0000_0000, 32'h0400_0000);
        drain();

        // 4: back-pressure through the skid entry
        bus.out_ready = 1'b0;
        send(5'd1, 2'd0, 32'h0, 32'h4000_0000);
        send(5'd2, 2'd0, 32'h0, 32'h2000_0000);
        chk("t4_ready_lo", 32'(bus.in_ready), 32'd0);
        chk("t4_sel_hold", bus.out_sel, 32'h4000_0000);
        offer(5'd3, 2'd0, 32'h0, 32'h1000_0000);
        repeat (3) begin
            step(a);
            chk("t4_no_acc", 32'(a), 32'd0);
        end
        bus.out_ready = 1'b1;
        wait_acc();
        drain();
        chk("t4_cnt", 32'(bus.word_cnt), 32'd8);

        // 5: reserved mode, sticky err
        chk("t5_err_pre", 32'(bus.err), 32'd0);
        send(5'd7, 2'd3, 32'h0, 32'h0100_0000);
        drain();
        chk("t5_err", 32'(bus.err), 32'd1);
        for (int i = 0; i < 10; i++) send(5'(i), 2'd0, 32'h0, 32'h8000_0000 >> i);
        drain();
        chk("t5_err_sticky", 32'(bus.err), 32'd1);

        // 6: sweep with random fill and random out_ready
        rnd_rdy = 1;
        for (int m = 0; m < 3; m++) begin
            for (int i = 0; i < 32; i++) begin
                f = $urandom();
                send(5'(i), 2'(m), f, model(5'(i), 2'(m), f));
            end
        end
        rnd_rdy = 0;
        drain();

        // Reset while stalled with both stages full
        bus.out_ready = 1'b0;
        send(5'd9,  2'd0, 32'h0, 32'h0040_0000);
        send(5'd10, 2'd0, 32'h0, 32'h0020_0000);
        rst_n = 1'b0;
        #1;
        chk("mr_valid", 32'(bus.out_valid), 32'd0);
        chk("mr_cnt",   32'(bus.word_cnt), 32'd0);
        chk("mr_err",   32'(bus.err), 32'd0);
        q.delete();
        exp_cnt    = '0;
        prev_stall = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("mr_ready", 32'(bus.in_ready), 32'd1);
        bus.out_ready = 1'b1;
        send(5'd12, 2'd1, 32'h0, 32'h000F_FFFF);
        drain();
        chk("mr_cnt_after", 32'(bus.word_cnt), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got=%0d exp=0", $time);
        $fatal(1);
    end

endmodule
